// File: rtl/debug_command_unit.sv
// Command-driven debug controller for NUM_HARTS cores: halt/resume/reset/step,
// register access through a request/ack port, and PC breakpoints that auto-halt a hart.
module debug_command_unit #(
    parameter int NUM_HARTS    = 2,
    parameter int XLEN         = 32,
    parameter int NUM_BP       = 4,
    parameter int RESET_CYCLES = 4,
    parameter int HALT_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    input  logic [31:0]               cmd_word,
    input  logic [XLEN-1:0]           cmd_wdata,
    output logic                      debugger_busy,
    output logic                      result_valid,
    output logic [XLEN-1:0]           debugger_result,
    output logic                      cmd_error,
    output logic [NUM_HARTS-1:0]      core_halt,
    output logic [NUM_HARTS-1:0]      core_reset,
    input  logic [NUM_HARTS-1:0]      core_busy,
    input  logic [NUM_HARTS-1:0]      core_retire,
    input  logic [NUM_HARTS*XLEN-1:0] core_pc,
    output logic                      port_req,
    output logic                      port_we,
    output logic [3:0]                port_hart,
    output logic [4:0]                port_addr,
    output logic [XLEN-1:0]           port_wdata,
    input  logic [XLEN-1:0]           port_rdata,
    input  logic                      port_ack,
    output logic [NUM_HARTS-1:0]      bp_hit
);
    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_WAIT_HALT, S_RESET_PULSE, S_PORT, S_STEP_RUN, S_DONE
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_HALT   = 4'd1;
    localparam logic [3:0] OP_RESUME = 4'd2;
    localparam logic [3:0] OP_RESET  = 4'd3;
    localparam logic [3:0] OP_READ   = 4'd4;
    localparam logic [3:0] OP_WRITE  = 4'd5;
    localparam logic [3:0] OP_SET_BP = 4'd6;
    localparam logic [3:0] OP_CLR_BP = 4'd7;
    localparam logic [3:0] OP_STEP   = 4'd8;

    state_t                state_q, state_d;
    logic [15:0]           cmd_q, cmd_d;
    logic [XLEN-1:0]       wdata_q, wdata_d, result_q, result_d;
    logic [15:0]           timer_q, timer_d;
    logic                  err_q, err_d;
    logic                  result_valid_q, result_valid_d;
    logic                  cmd_error_q, cmd_error_d;
    logic [NUM_HARTS-1:0]  core_halt_q, core_halt_d;
    logic [NUM_HARTS-1:0]  core_reset_q, core_reset_d;
    logic [NUM_HARTS-1:0]  bp_hit_q, bp_hit_d;
    logic [NUM_BP-1:0]     bp_en_q, bp_en_d;
    logic [3:0]            bp_hart_q [NUM_BP];
    logic [3:0]            bp_hart_d [NUM_BP];
    logic [XLEN-1:0]       bp_pc_q [NUM_BP];
    logic [XLEN-1:0]       bp_pc_d [NUM_BP];

    logic [3:0]            opcode, hart;
    logic [7:0]            idx;
    logic [NUM_HARTS-1:0]  hart_oh, bp_match, step_mask, fire;
    logic [NUM_BP-1:0]     bp_oh;
    logic                  hart_ok, bp_ok, sel_halted, sel_busy, sel_retire, needs_hart;
    logic                  unused_cmd_hi;

    assign unused_cmd_hi = ^cmd_word[31:16];
    assign opcode = cmd_q[3:0];
    assign hart   = cmd_q[7:4];
    assign idx    = cmd_q[15:8];

    // One-hot selects avoid indexing narrow vectors with the 4/8-bit command fields.
    always_comb begin
        hart_oh  = '0;
        bp_oh    = '0;
        bp_match = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (hart == 4'(h)) hart_oh[h] = 1'b1;
        end
        for (int b = 0; b < NUM_BP; b++) begin
            if (idx == 8'(b)) bp_oh[b] = 1'b1;
        end
        for (int h = 0; h < NUM_HARTS; h++) begin
            for (int b = 0; b < NUM_BP; b++) begin
                if (bp_en_q[b] && bp_hart_q[b] == 4'(h) &&
                    bp_pc_q[b] == core_pc[h*XLEN +: XLEN]) bp_match[h] = 1'b1;
            end
        end
    end

    assign hart_ok    = |hart_oh;
    assign bp_ok      = |bp_oh;
    assign sel_halted = |(core_halt_q & hart_oh);
    assign sel_busy   = |(core_busy & hart_oh);
    assign sel_retire = |(core_retire & hart_oh);
    assign needs_hart = (opcode != OP_NOP) && (opcode != OP_CLR_BP);
    // A stepping hart runs past its breakpoints; halted harts cannot re-trigger.
    assign step_mask  = (state_q == S_STEP_RUN) ? hart_oh : '0;
    assign fire       = bp_match & ~core_halt_q & ~step_mask;

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        wdata_d        = wdata_q;
        result_d       = result_q;
        timer_d        = timer_q;
        err_d          = err_q;
        result_valid_d = 1'b0;
        cmd_error_d    = 1'b0;
        core_halt_d    = core_halt_q | fire;
        core_reset_d   = core_reset_q;
        bp_hit_d       = bp_hit_q | fire;
        bp_en_d        = bp_en_q;
        bp_hart_d      = bp_hart_q;
        bp_pc_d        = bp_pc_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d   = cmd_word[15:0];
                    wdata_d = cmd_wdata;
                    err_d   = 1'b0;
                    timer_d = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_DONE;
                timer_d = '0;
                if (opcode > OP_STEP) begin
                    err_d = 1'b1;
                end else if (needs_hart && !hart_ok) begin
                    err_d = 1'b1;
                end else if ((opcode == OP_SET_BP || opcode == OP_CLR_BP) && !bp_ok) begin
                    err_d = 1'b1;
                end else if ((opcode == OP_READ || opcode == OP_WRITE || opcode == OP_STEP)
                             && !sel_halted) begin
                    err_d = 1'b1;
                end else begin
                    case (opcode)
                        OP_HALT: begin
                            core_halt_d = core_halt_d | hart_oh;
                            if (!sel_halted) state_d = S_WAIT_HALT;
                        end
                        OP_RESUME: begin
                            core_halt_d = core_halt_d & ~hart_oh;
                            bp_hit_d    = bp_hit_d & ~hart_oh;
                        end
                        OP_RESET: begin
                            core_reset_d = hart_oh;
                            bp_hit_d     = bp_hit_d & ~hart_oh;
                            state_d      = S_RESET_PULSE;
                        end
                        OP_READ, OP_WRITE: state_d = S_PORT;
                        OP_SET_BP: begin
                            for (int b = 0; b < NUM_BP; b++) begin
                                if (bp_oh[b]) begin
                                    bp_en_d[b]   = 1'b1;
                                    bp_hart_d[b] = hart;
                                    bp_pc_d[b]   = wdata_q;
                                end
                            end
                        end
                        OP_CLR_BP: bp_en_d = bp_en_q & ~bp_oh;
                        OP_STEP: begin
                            core_halt_d = core_halt_d & ~hart_oh;
                            bp_hit_d    = bp_hit_d & ~hart_oh;
                            state_d     = S_STEP_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_WAIT_HALT: begin
                if (!sel_busy) begin
                    state_d = S_DONE;
                end else if (timer_q == 16'(HALT_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_RESET_PULSE: begin
                if (timer_q == 16'(RESET_CYCLES - 1)) begin
                    core_reset_d = '0;
                    state_d      = S_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_PORT: begin
                if (port_ack) begin
                    if (opcode == OP_READ) result_d = port_rdata;
                    state_d = S_DONE;
                end
            end
            S_STEP_RUN: begin
                if (sel_retire) begin
                    core_halt_d = core_halt_d | hart_oh;
                    timer_d     = '0;
                    state_d     = S_WAIT_HALT;
                end
            end
            S_DONE: begin
                result_valid_d = 1'b1;
                cmd_error_d    = err_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cmd_q          <= '0;
            wdata_q        <= '0;
            result_q       <= '0;
            timer_q        <= '0;
            err_q          <= 1'b0;
            result_valid_q <= 1'b0;
            cmd_error_q    <= 1'b0;
            core_halt_q    <= '0;
            core_reset_q   <= '0;
            bp_hit_q       <= '0;
            bp_en_q        <= '0;
            for (int b = 0; b < NUM_BP; b++) begin
                bp_hart_q[b] <= '0;
                bp_pc_q[b]   <= '0;
            end
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            wdata_q        <= wdata_d;
            result_q       <= result_d;
            timer_q        <= timer_d;
            err_q          <= err_d;
            result_valid_q <= result_valid_d;
            cmd_error_q    <= cmd_error_d;
            core_halt_q    <= core_halt_d;
            core_reset_q   <= core_reset_d;
            bp_hit_q       <= bp_hit_d;
            bp_en_q        <= bp_en_d;
            bp_hart_q      <= bp_hart_d;
            bp_pc_q        <= bp_pc_d;
        end
    end

    assign debugger_busy   = (state_q != S_IDLE);
    assign result_valid    = result_valid_q;
    assign debugger_result = result_q;
    assign cmd_error       = cmd_error_q;
    assign core_halt       = core_halt_q;
    assign core_reset      = core_reset_q;
    assign bp_hit          = bp_hit_q;
    assign port_req        = (state_q == S_PORT);
    assign port_we         = port_req && (opcode == OP_WRITE);
    assign port_hart       = hart;
    assign port_addr       = cmd_q[12:8];
    assign port_wdata      = wdata_q;
endmodule

// File: tb/tb_debug_command_unit.sv
// Directed bench for debug_command_unit: hand-computed latencies and side effects
// for halt, timeout, reset, register access, breakpoints and step.
module tb_debug_command_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [31:0] cmd_word;
    logic [31:0] cmd_wdata;
    logic        debugger_busy;
    logic        result_valid;
    logic [31:0] debugger_result;
    logic        cmd_error;
    logic [1:0]  core_halt;
    logic [1:0]  core_reset;
    logic [1:0]  core_busy;
    logic [1:0]  core_retire;
    logic [63:0] core_pc;
    logic        port_req;
    logic        port_we;
    logic [3:0]  port_hart;
    logic [4:0]  port_addr;
    logic [31:0] port_wdata;
    logic [31:0] port_rdata;
    logic        port_ack;
    logic [1:0]  bp_hit;

    int tests = 0;
    int fails = 0;
    int lat;
    int hi0;
    int hi1;

    debug_command_unit dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
        .cmd_wdata(cmd_wdata), .debugger_busy(debugger_busy), .result_valid(result_valid),
        .debugger_result(debugger_result), .cmd_error(cmd_error), .core_halt(core_halt),
        .core_reset(core_reset), .core_busy(core_busy), .core_retire(core_retire),
        .core_pc(core_pc), .port_req(port_req), .port_we(port_we), .port_hart(port_hart),
        .port_addr(port_addr), .port_wdata(port_wdata), .port_rdata(port_rdata),
        .port_ack(port_ack), .bp_hit(bp_hit)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic send(input logic [31:0] word, input logic [31:0] wdata);
        int guard = 0;
        while (debugger_busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("send_idle", debugger_busy, 1'b0);
        cmd_valid = 1'b1;
        cmd_word  = word;
        cmd_wdata = wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // cyc = number of rising edges after the one that accepted the command.
    task automatic wait_result(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!result_valid && cyc < budget);
        check("result_arrived", result_valid, 1'b1);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_word = '0; cmd_wdata = '0;
        core_busy = '0; core_retire = '0; core_pc = '0;
        port_rdata = '0; port_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", debugger_busy, 1'b0);
        check("rst_rv", result_valid, 1'b0);
        check("rst_halt", core_halt, 2'b00);
        check("rst_creset", core_reset, 2'b00);
        check("rst_bphit", bp_hit, 2'b00);
        check("rst_preq", port_req, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // NOP: two cycles, busy while in flight
        send(32'h0, 32'h0);
        check("nop_busy", debugger_busy, 1'b1);
        wait_result(10, lat);
        check("nop_lat", lat, 2);
        check("nop_err", cmd_error, 1'b0);
        check("nop_busy_clr", debugger_busy, 1'b0);

        // HALT hart0 while core busy for several cycles
        core_busy = 2'b01;
        send(32'h01, 32'h0);
        repeat (4) @(negedge clk);
        check("halt_wait_rv", result_valid, 1'b0);
        check("halt_wait_lvl", core_halt, 2'b01);
        core_busy = 2'b00;
        wait_result(10, lat);
        check("halt_lat_after_busy", lat, 2);
        check("halt_err", cmd_error, 1'b0);
        check("halt_lvl", core_halt, 2'b01);

        // Halting an already-halted hart
        send(32'h01, 32'h0);
        wait_result(10, lat);
        check("rehalt_lat", lat, 2);
        check("rehalt_err", cmd_error, 1'b0);

        // Reset in the middle of a HALT
        core_busy = 2'b10;
        send(32'h11, 32'h0);
        @(negedge clk);
        check("midrst_pre_halt", core_halt, 2'b11);
        rst = 1'b1;
        #1;
        check("midrst_halt", core_halt, 2'b00);
        check("midrst_busy", debugger_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_rv", result_valid, 1'b0);
        end
        core_busy = 2'b00;

        // HALT timeout with core_busy stuck high
        core_busy = 2'b01;
        send(32'h01, 32'h0);
        wait_result(100, lat);
        check("timeout_lat", lat, 66);
        check("timeout_err", cmd_error, 1'b1);
        check("timeout_halt", core_halt, 2'b01);
        core_busy = 2'b00;

        // HALT hart1, not busy: one WAIT_HALT cycle
        send(32'h11, 32'h0);
        wait_result(10, lat);
        check("halt1_lat", lat, 3);
        check("halt1_err", cmd_error, 1'b0);
        check("halt1_lvl", core_halt, 2'b11);

        // READ_REG idx3 hart1, ack after 3 cycles
        send(32'h0000_0314, 32'h0);
        @(negedge clk);
        check("rd_req", port_req, 1'b1);
        check("rd_we", port_we, 1'b0);
        check("rd_hart", port_hart, 4'd1);
        check("rd_addr", port_addr, 5'd3);
        repeat (2) @(negedge clk);
        port_ack = 1'b1;
        port_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        port_ack = 1'b0;
        port_rdata = 32'h0;
        wait_result(10, lat);
        check("rd_data", debugger_result, 32'hDEAD_BEEF);
        check("rd_err", cmd_error, 1'b0);

        // WRITE_REG idx5 hart0 with ack in the same cycle as req
        port_ack = 1'b1;
        send(32'h0000_0505, 32'h0000_1234);
        @(negedge clk);
        check("wr_req", port_req, 1'b1);
        check("wr_we", port_we, 1'b1);
        check("wr_wdata", port_wdata, 32'h0000_1234);
        check("wr_addr", port_addr, 5'd5);
        @(negedge clk);
        @(negedge clk);
        check("wr_rv", result_valid, 1'b1);
        check("wr_err", cmd_error, 1'b0);
        check("wr_result_kept", debugger_result, 32'hDEAD_BEEF);
        port_ack = 1'b0;

        // Error cases
        send(32'h21, 32'h0);
        wait_result(10, lat);
        check("badhart_lat", lat, 2);
        check("badhart_err", cmd_error, 1'b1);
        check("badhart_halt", core_halt, 2'b11);
        send(32'h0F, 32'h0);
        wait_result(10, lat);
        check("op15_err", cmd_error, 1'b1);
        send(32'h0000_0406, 32'h100);
        wait_result(10, lat);
        check("badbp_err", cmd_error, 1'b1);

        // Breakpoint bp0 on hart0 at PC 0x100
        send(32'h06, 32'h100);
        wait_result(10, lat);
        check("setbp_lat", lat, 2);
        check("setbp_err", cmd_error, 1'b0);
        send(32'h02, 32'h0);
        wait_result(10, lat);
        check("resume_lat", lat, 2);
        check("resume_halt", core_halt, 2'b10);
        core_pc[31:0] = 32'h100;
        @(negedge clk);
        check("bp_halt", core_halt, 2'b11);
        check("bp_hit", bp_hit, 2'b01);

        // RESUME at matching PC: breakpoint fires again right after
        send(32'h02, 32'h0);
        wait_result(10, lat);
        check("refire_halt", core_halt, 2'b11);
        check("refire_hit", bp_hit, 2'b01);

        // CLR_BP then RESUME: stays running
        send(32'h07, 32'h0);
        wait_result(10, lat);
        check("clrbp_err", cmd_error, 1'b0);
        send(32'h02, 32'h0);
        wait_result(10, lat);
        repeat (2) @(negedge clk);
        check("clrbp_halt", core_halt, 2'b10);
        check("clrbp_hit", bp_hit, 2'b00);

        // STEP on running hart0 is an error
        send(32'h08, 32'h0);
        wait_result(10, lat);
        check("step_run_err", cmd_error, 1'b1);
        check("step_run_halt", core_halt, 2'b10);

        // STEP on halted hart1
        send(32'h18, 32'h0);
        @(negedge clk);
        check("step_released", core_halt, 2'b00);
        core_retire = 2'b10;
        @(negedge clk);
        core_retire = 2'b00;
        check("step_rehalt", core_halt, 2'b10);
        wait_result(10, lat);
        check("step_err", cmd_error, 1'b0);
        check("step_halt_final", core_halt, 2'b10);

        // RESET hart0: pulse width and latency
        send(32'h03, 32'h0);
        hi0 = 0;
        hi1 = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (core_reset[0]) hi0++;
            if (core_reset[1]) hi1++;
        end while (!result_valid && lat < 20);
        check("reset_rv", result_valid, 1'b1);
        check("reset_width", hi0, 4);
        check("reset_other", hi1, 0);
        check("reset_lat", lat, 6);
        check("reset_halt", core_halt, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
